// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller for the async FIFO: write-pointer synchroniser, read pointers, empty/underflow.
// Define RPTR_LEVEL_EN to enable the registered fill-level output; otherwise level is tied to 0.
module fifo_rd_ctrl #(
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 r_en,
    input  logic                 clr_underflow,
    input  logic [PTR_WIDTH-1:0] g_wptr_async,
    output logic [PTR_WIDTH-1:0] b_rptr,
    output logic [PTR_WIDTH-1:0] g_rptr,
    output logic                 empty,
    output logic                 rd_valid,
    output logic                 underflow,
    output logic [PTR_WIDTH-1:0] level
);

    localparam int unsigned NS = SYNC_STAGES;
    localparam int unsigned PW = PTR_WIDTH;

    logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [PTR_WIDTH-1:0] g_wptr_sync;
    logic [PTR_WIDTH-1:0] b_rptr_next;
    logic [PTR_WIDTH-1:0] g_rptr_next;
    logic                 rd_acc;

    // Plain flop chain only: nothing may sit between synchroniser stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int unsigned i = 0; i < NS; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= g_wptr_async;
            for (int unsigned i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_wptr_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        rd_acc      = r_en & ~empty;
        b_rptr_next = b_rptr + PTR_WIDTH'(rd_acc);
        g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_rptr    <= '0;
            g_rptr    <= '0;
            empty     <= 1'b1;
            rd_valid  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            b_rptr   <= b_rptr_next;
            g_rptr   <= g_rptr_next;
            empty    <= (g_rptr_next == g_wptr_sync);
            rd_valid <= rd_acc;
            if (r_en & empty)
                underflow <= 1'b1;
            else if (clr_underflow)
                underflow <= 1'b0;
        end
    end

`ifdef RPTR_LEVEL_EN
    logic [PTR_WIDTH-1:0] b_wptr_sync;

    // Bit i of the binary pointer is the XOR of all Gray bits from i upward.
    always_comb begin
        b_wptr_sync = '0;
        for (int unsigned i = 0; i < PW; i++) b_wptr_sync[i] = ^(g_wptr_sync >> i);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            level <= '0;
        else
            level <= b_wptr_sync - b_rptr_next;
    end
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised, self-checking bench for fifo_rd_ctrl against an occupancy-count reference model.
module tb_fifo_rd_ctrl;

    localparam int PW   = 4;
    localparam int SYNC = 2;
    localparam int MOD  = 16;
`ifdef RPTR_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          r_en = 1'b0;
    logic          clr_underflow = 1'b0;
    logic [PW-1:0] g_wptr_async = '0;
    logic [PW-1:0] b_rptr, g_rptr, level;
    logic          empty, rd_valid, underflow;

    fifo_rd_ctrl #(.PTR_WIDTH(PW), .SYNC_STAGES(SYNC)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .r_en(r_en), .clr_underflow(clr_underflow),
        .g_wptr_async(g_wptr_async), .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty),
        .rd_valid(rd_valid), .underflow(underflow), .level(level)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input int n);
        int b;
        b = n % MOD;
        return b ^ (b >> 1);
    endfunction

    // Reference model: counts of entries written, read and visible to the reader.
    int wcount = 0;
    int m_rptr, m_level, wsync;
    bit m_empty, m_rdv, m_und, acc;
    int wq[$];

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_rptr = 0; m_level = 0; m_empty = 1'b1; m_rdv = 1'b0; m_und = 1'b0;
            wq = {};
            for (int i = 0; i < SYNC; i++) wq.push_back(0);
        end else begin
            wsync = wq[0];
            acc = r_en && !m_empty;
            if (r_en && m_empty) m_und = 1'b1;
            else if (clr_underflow) m_und = 1'b0;
            m_rptr  = (m_rptr + int'(acc)) % MOD;
            m_level = ((wsync - m_rptr) % MOD + MOD) % MOD;
            m_empty = (m_level == 0);
            m_rdv   = acc;
            void'(wq.pop_front());
            wq.push_back(wcount % MOD);
        end
    end

    int  prev_b = 0;
    bit  saw_wrap = 1'b0;

    always @(negedge wclk) begin
        if (wrst_n && run) begin
            chk("b_rptr",    int'(b_rptr),    m_rptr);
            chk("g_rptr",    int'(g_rptr),    gray(m_rptr));
            chk("empty",     int'(empty),     int'(m_empty));
            chk("rd_valid",  int'(rd_valid),  int'(m_rdv));
            chk("underflow", int'(underflow), int'(m_und));
            chk("level",     int'(level),     LVL ? m_level : 0);
            if (prev_b == 15 && b_rptr == 0) saw_wrap = 1'b1;
            prev_b = int'(b_rptr);
        end
    end

    task automatic set_w(input int n);
        wcount = n;
        g_wptr_async = PW'(gray(n));
    endtask

    int pulses;
    int diff;

    initial begin
        wrst_n = 1'b1;
        #1 wrst_n = 1'b0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        run = 1'b1;
        @(negedge wclk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_rdv",   int'(rd_valid), 0);
        chk("rst_bptr",  int'(b_rptr), 0);
        chk("rst_und",   int'(underflow), 0);

        // Fill three entries, then drain with one extra request.
        set_w(3);
        repeat (2) @(negedge wclk);
        chk("fill_not_yet", int'(empty), 1);
        @(negedge wclk);
        chk("fill_empty", int'(empty), 0);
        chk("fill_level", int'(level), LVL ? 3 : 0);
        pulses = 0;
        r_en = 1'b1;
        repeat (4) begin
            @(negedge wclk);
            pulses += int'(rd_valid);
        end
        r_en = 1'b0;
        chk("drain_pulses", pulses, 3);
        chk("drain_bptr",   int'(b_rptr), 3);
        chk("drain_gptr",   int'(g_rptr), 2);
        chk("drain_empty",  int'(empty), 1);
        chk("drain_und",    int'(underflow), 1);

        clr_underflow = 1'b1;
        @(negedge wclk);
        clr_underflow = 1'b0;
        chk("clr_und", int'(underflow), 0);
        r_en = 1'b1;
        @(negedge wclk);
        chk("reset_und", int'(underflow), 1);
        clr_underflow = 1'b1;
        @(negedge wclk);
        chk("set_wins", int'(underflow), 1);
        r_en = 1'b0;
        clr_underflow = 1'b0;

        // Asynchronous reset in the middle of a read.
        set_w(5);
        repeat (3) @(negedge wclk);
        chk("pre_rst_empty", int'(empty), 0);
        r_en = 1'b1;
        @(posedge wclk);
        #2 wrst_n = 1'b0;
        #1;
        chk("async_empty", int'(empty), 1);
        chk("async_rdv",   int'(rd_valid), 0);
        chk("async_bptr",  int'(b_rptr), 0);
        chk("async_gptr",  int'(g_rptr), 0);
        set_w(0);
        r_en = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        repeat (2) @(negedge wclk);
        chk("post_rst_bptr", int'(b_rptr), 0);

        // Completely full buffer.
        set_w(8);
        repeat (2) @(negedge wclk);
        chk("full_not_yet", int'(empty), 1);
        @(negedge wclk);
        chk("full_empty", int'(empty), 0);
        chk("full_level", int'(level), LVL ? 8 : 0);
        r_en = 1'b1;
        repeat (8) @(negedge wclk);
        r_en = 1'b0;
        chk("full_bptr",  int'(b_rptr), 8);
        chk("full_drain", int'(empty), 1);
        chk("full_und",   int'(underflow), 0);

        // Streaming through the pointer wrap.
        r_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_w(wcount + 1);
            @(negedge wclk);
        end
        repeat (6) @(negedge wclk);
        r_en = 1'b0;
        chk("wrap_seen", int'(saw_wrap), 1);

        // Random traffic, never exceeding the FIFO depth.
        for (int i = 0; i < 600; i++) begin
            r_en = ($urandom_range(0, 3) != 0);
            clr_underflow = ($urandom_range(0, 7) == 0);
            diff = ((wcount % MOD - m_rptr) % MOD + MOD) % MOD;
            if (diff < 8 && $urandom_range(0, 2) != 0) set_w(wcount + 1);
            @(negedge wclk);
        end
        r_en = 1'b0;
        clr_underflow = 1'b0;
        repeat (4) @(negedge wclk);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side pointer controller for the asynchronous FIFO used between the UART datapath and the host interface; the consumer-side counterpart of the write-pointer handler. It synchronises the incoming Gray write pointer through a multi-flop synchroniser, maintains binary and Gray read pointers, and generates a registered empty flag. It also generates a read-data-valid strobe aligned with the FIFO RAM read port, a sticky underflow flag, and an optional fill level.

## Interface
- PTR_WIDTH, 4: pointer width including wrap bit; FIFO depth = 2^(PTR_WIDTH-1); minimum 3.
- SYNC_STAGES, 2: flops in the write-pointer synchroniser; minimum 2.
- wclk  input  1  consumer-domain clock; all state in this block is clocked by wclk (rising edge).
- wrst_n  input  1  reset, asynchronous, active-low.
- r_en  input  1  read request from consumer.
- clr_underflow  input  1  synchronous clear of the underflow flag.
- g_wptr_async  input  PTR_WIDTH  Gray write pointer from producer domain, unsynchronised.
- b_rptr  output  PTR_WIDTH  binary read pointer; low PTR_WIDTH-1 bits address the RAM.
- g_rptr  output  PTR_WIDTH  Gray read pointer, registered, exported to producer domain.
- empty  output  1  FIFO empty, registered.
- rd_valid  output  1  RAM read data valid this cycle.
- underflow  output  1  sticky: read requested while empty.
- level  output  PTR_WIDTH  entries held, 0..2^(PTR_WIDTH-1).

## Operation
- Synchroniser: g_wptr_async is shifted through SYNC_STAGES flops; the last stage is g_wptr_sync. No other logic may sit between the stages.
- Accept: rd_acc = r_en & ~empty. b_rptr_next = b_rptr + rd_acc (modulo 2^PTR_WIDTH). g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1).
- b_rptr and g_rptr register b_rptr_next and g_rptr_next every cycle. g_rptr is driven directly from a flop; no glitching combinational path to the producer domain.
- Empty: empty <= (g_rptr_next == g_wptr_sync). Equality is on all PTR_WIDTH bits, with no inversion.
- rd_valid <= rd_acc. Data at RAM address b_rptr[PTR_WIDTH-2:0], sampled on the accepting edge, is valid while rd_valid is high.
- Underflow: set when r_en & empty. Cleared by clr_underflow. Set wins if both occur in the same cycle. Pointers never move on an underflowing request.
- Gray-to-binary: b_wptr_sync[i] = XOR of g_wptr_sync[PTR_WIDTH-1:i].
- Wrap-around: pointers wrap from 2^PTR_WIDTH-1 to 0 with no special handling. The wrap bit distinguishes the full pointer state from empty.
- Reset: asynchronous assertion clears all state, including synchroniser flops. Any read in flight is discarded; rd_valid drops immediately.

## Timing
- Reset values: b_rptr=0, g_rptr=0, empty=1, rd_valid=0, underflow=0, level=0, synchroniser stages=0.
- Read latency: r_en high with empty low at edge N gives b_rptr/g_rptr advanced and rd_valid=1 after edge N; the data-valid cycle is N+1.
- Sustained reads: one entry per cycle while empty stays low.
- Last-entry read: if g_rptr_next equals g_wptr_sync, empty rises on the same edge that advances the pointer. A read request in the following cycle is not accepted and sets underflow.
- Write visibility: a change on g_wptr_async reaches g_wptr_sync after SYNC_STAGES edges. empty and level update one edge later, SYNC_STAGES+1 edges in total. This is pessimistic only: empty may read high late, never low early.
- Simultaneous write arrival and last-entry read: empty is computed from g_rptr_next against the current g_wptr_sync, so the result is correct in the same cycle.

## Configuration
- RPTR_LEVEL_EN defined: level <= (b_wptr_sync - b_rptr_next) mod 2^PTR_WIDTH, registered, with the same timing as empty. level=0 exactly when empty=1.
- RPTR_LEVEL_EN undefined: the level output is tied to 0, and the Gray-to-binary converter and subtractor are removed. The empty, pointer and underflow behaviour is unchanged.

## Test plan
All scenarios use PTR_WIDTH=4 and SYNC_STAGES=2 unless stated.
- Reset: assert wrst_n=0 mid-read -> empty=1, rd_valid=0, b_rptr=0, g_rptr=0 without waiting for a clock edge; pointers remain 0 after release.
- Fill then drain: set g_wptr_async to Gray(3)=4'b0010 -> empty falls 3 edges later and level=3. Hold r_en for 4 cycles -> 3 rd_valid pulses, b_rptr=3, g_rptr=4'b0010, empty=1, underflow=1 after the 4th request.
- Underflow clear: with underflow=1, pulse clr_underflow with r_en=0 -> underflow=0 the next cycle. Repeat with r_en=1 and empty=1 -> underflow stays 1.
- Wrap-around: step the write and read pointers through 20 entries at one entry per cycle -> b_rptr passes 15->0, g_rptr passes 4'b1000->4'b0000, and no false empty occurs while level>0.
- Full buffer: g_wptr_async=Gray(8)=4'b1100 with read pointer 0 -> empty=0, level=8. Eight reads -> empty=1, b_rptr=8.
- Macro off: build without RPTR_LEVEL_EN and rerun the fill/drain scenario -> level=0 throughout; empty and rd_valid match the macro-on run cycle for cycle.
